// File: rtl/seq_detect_scheduler_if.sv
// Word-in / result-out handshake plus the detector side-band of the sequence-detect scheduler.
interface seq_detect_scheduler_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 4
);
    // word producer side
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              in_keep;
    logic              flush;

    // detector side
    logic              det_bit;
    logic              det_clr;
    logic              det_hit;

    // result consumer side
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_last;

    // scheduler view
    modport slave (
        input  in_valid, in_word, in_keep, flush, det_hit, out_ready,
        output in_ready, det_bit, det_clr, out_valid, out_count, out_last
    );

    // producer / detector / consumer view
    modport master (
        output in_valid, in_word, in_keep, flush, det_hit, out_ready,
        input  in_ready, det_bit, det_clr, out_valid, out_count, out_last
    );
endinterface

// File: rtl/seq_detect_scheduler.sv
// Serializes words MSB-first into a Mealy sequence detector, optionally clearing it first,
// and reports the number of detector hits per word on a valid/ready result port.
module seq_detect_scheduler #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_detect_scheduler_if.slave bus
);
    localparam int unsigned       IDX_W    = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    // elaboration-time parameter sanity
    if (WORD_W < 2) begin : g_bad_word_w
        $error("seq_detect_scheduler: WORD_W must be at least 2");
    end
    if (CNT_W < $clog2(WORD_W + 1)) begin : g_bad_cnt_w
        $error("seq_detect_scheduler: CNT_W too narrow for WORD_W hits");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_nxt;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  bit_idx_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              force_clr;
    logic              force_clr_nxt;

    logic              det_bit_q;
    logic              det_clr_q;
    logic              out_valid_q;
    logic [CNT_W-1:0]  out_count_q;
    logic [CNT_W-1:0]  out_count_nxt;
    logic              out_last_q;
    logic              out_last_nxt;

    logic              in_ready_c;
    logic              accept_c;

    // Ready only out of reset, never during flush; in DONE the result handshake frees the slot.
    always_comb begin
        in_ready_c = 1'b0;
        if (reset && !bus.flush) begin
            in_ready_c = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
        end
        accept_c = in_ready_c && bus.in_valid;
    end

    // Next-state and datapath updates; flush overrides every handshake.
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_idx_nxt   = bit_idx;
        cnt_nxt       = cnt;
        force_clr_nxt = force_clr;
        out_count_nxt = out_count_q;
        out_last_nxt  = out_last_q;

        if (bus.flush) begin
            state_nxt     = ST_IDLE;
            force_clr_nxt = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_IDLE;
                end
                ST_CLEAR: begin
                    state_nxt = ST_SHIFT;
                end
                ST_SHIFT: begin
                    // det_hit belongs to the bit currently on det_bit
                    if (bus.det_hit && (cnt != CNT_MAX)) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                    shreg_nxt   = shreg << 1;
                    bit_idx_nxt = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_LAST) begin
                        state_nxt     = ST_DONE;
                        out_count_nxt = cnt_nxt;
                        out_last_nxt  = bus.det_hit;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase

            // a new word may be taken from IDLE or back-to-back from DONE
            if (accept_c) begin
                shreg_nxt     = bus.in_word;
                bit_idx_nxt   = '0;
                cnt_nxt       = '0;
                force_clr_nxt = 1'b0;
                state_nxt     = (!bus.in_keep || force_clr) ? ST_CLEAR : ST_SHIFT;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            cnt       <= '0;
            force_clr <= 1'b1;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_idx   <= bit_idx_nxt;
            cnt       <= cnt_nxt;
            force_clr <= force_clr_nxt;
        end
    end

    // Registered outputs, decoded from the upcoming state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            det_bit_q   <= 1'b0;
            det_clr_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            det_bit_q   <= (state_nxt == ST_SHIFT) && shreg_nxt[WORD_W-1];
            det_clr_q   <= (state_nxt == ST_CLEAR);
            out_valid_q <= (state_nxt == ST_DONE);
            out_count_q <= out_count_nxt;
            out_last_q  <= out_last_nxt;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.det_bit   = det_bit_q;
    assign bus.det_clr   = det_clr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: an overlapping "110" detector on det_*, directed cases
// followed by random words, expected results from a bit-history model.
module tb_seq_detect_scheduler;
    localparam int WORD_W  = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    seq_detect_scheduler_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

    seq_detect_scheduler #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // single comparison point
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // detector responder: advances only in the bench-scheduled bit window of the current word
    int   cyc      = 0;
    int   win_base = -1000;
    int   win_clr  = 0;
    int   det_st   = 0;
    logic in_win;

    assign in_win      = (cyc >= win_base + win_clr) && (cyc <= win_base + win_clr + WORD_W - 1);
    assign bus.det_hit = in_win && (det_st == 2) && !bus.det_bit;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.det_clr) det_st <= 0;
        else if (in_win) det_st <= bus.det_bit ? ((det_st == 2) ? 2 : det_st + 1) : 0;
    end

    // reference model: bit history since the last detector clear
    bit hist[$];
    bit m_force = 1'b1;

    function automatic bit push_bit(input bit b);
        int n;
        hist.push_back(b);
        n = hist.size();
        return (n >= 3) && hist[n-3] && hist[n-2] && !hist[n-1];
    endfunction

    // abort: 0 none, 1 flush, 2 async reset, at bit index abort_at
    task automatic send_word(input logic [WORD_W-1:0] w, input bit keep, input int abort,
                             input int abort_at, input int hold,
                             output int waits, output int got_cnt);
        int  c;
        int  cnt;
        int  i;
        bit  hit;
        bit  last;
        bit  b;
        got_cnt = -1;
        waits   = 0;
        bus.in_word  = w;
        bus.in_keep  = keep;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && waits < 50) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        c = (!keep || m_force) ? 1 : 0;
        m_force = 1'b0;
        if (c == 1) hist.delete();
        win_base = cyc;
        win_clr  = c;
        cnt  = 0;
        last = 1'b0;
        for (int k = 1; k <= c + WORD_W + 1; k++) begin
            @(negedge clk);
            i = k - 1 - c;
            b = (i >= 0 && i < WORD_W) ? w[WORD_W-1-i] : 1'b0;
            check("det_clr", int'(bus.det_clr), (c == 1 && k == 1) ? 1 : 0);
            check("det_bit", int'(bus.det_bit), int'(b));
            check("out_valid", int'(bus.out_valid), (k == c + WORD_W + 1) ? 1 : 0);
            if (i >= 0 && i < WORD_W) begin
                if (abort != 0 && i == abort_at) begin
                    m_force = 1'b1;
                    if (abort == 1) begin
                        bus.flush = 1'b1;
                        #1;
                        check("flush_in_ready", int'(bus.in_ready), 0);
                        @(posedge clk);
                        #1;
                        bus.flush = 1'b0;
                        @(negedge clk);
                        check("flush_out_valid", int'(bus.out_valid), 0);
                        check("flush_det_bit", int'(bus.det_bit), 0);
                        check("flush_idle_ready", int'(bus.in_ready), 1);
                    end else begin
                        reset = 1'b0;
                        #1;
                        check("rst_det_bit", int'(bus.det_bit), 0);
                        check("rst_det_clr", int'(bus.det_clr), 0);
                        check("rst_out_valid", int'(bus.out_valid), 0);
                        check("rst_out_count", int'(bus.out_count), 0);
                        check("rst_out_last", int'(bus.out_last), 0);
                        check("rst_in_ready", int'(bus.in_ready), 0);
                        @(negedge clk);
                        reset = 1'b1;
                    end
                    return;
                end
                hit = push_bit(b);
                if (hit && cnt < CNT_MAX) cnt++;
                if (i == WORD_W - 1) last = hit;
            end
        end
        check("out_count", int'(bus.out_count), cnt);
        check("out_last", int'(bus.out_last), int'(last));
        got_cnt = int'(bus.out_count);
        if (hold > 0) begin
            bus.out_ready = 1'b0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_valid", int'(bus.out_valid), 1);
                check("hold_count", int'(bus.out_count), cnt);
                check("hold_last", int'(bus.out_last), int'(last));
                check("hold_in_ready", int'(bus.in_ready), 0);
            end
            bus.out_ready = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("idle_out_valid", int'(bus.out_valid), 0);
            check("idle_det_clr", int'(bus.det_clr), 0);
            check("idle_det_bit", int'(bus.det_bit), 0);
        end
    endtask

    int waits;
    int got;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.in_keep   = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // reset values
        repeat (2) @(negedge clk);
        check("reset_det_bit", int'(bus.det_bit), 0);
        check("reset_det_clr", int'(bus.det_clr), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_count", int'(bus.out_count), 0);
        check("reset_out_last", int'(bus.out_last), 0);
        check("reset_in_ready", int'(bus.in_ready), 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_in_ready", int'(bus.in_ready), 1);

        // first word: cleared, two hits
        send_word(8'h6D, 1'b0, 0, 0, 0, waits, got);
        check("t1_count", got, 2);
        idle(1);

        // back-to-back words with clears
        send_word(8'hDB, 1'b0, 0, 0, 0, waits, got);
        check("t2_count_db", got, 2);
        send_word(8'h03, 1'b0, 0, 0, 0, waits, got);
        check("t2_count_03", got, 0);
        idle(1);

        // keep carries the "11" tail into the next word
        send_word(8'h03, 1'b0, 0, 0, 0, waits, got);
        send_word(8'h00, 1'b1, 0, 0, 0, waits, got);
        check("t3_keep_count", got, 1);
        send_word(8'h03, 1'b0, 0, 0, 0, waits, got);
        send_word(8'h00, 1'b0, 0, 0, 0, waits, got);
        check("t3_clear_count", got, 0);
        idle(2);

        // result held in DONE, then back-to-back accept
        send_word(8'h6D, 1'b0, 0, 0, 5, waits, got);
        send_word(8'hDB, 1'b1, 0, 0, 0, waits, got);
        check("t4_b2b_waits", waits, 0);
        idle(1);

        // flush mid-word, then keep=1 word still clears
        send_word(8'h6D, 1'b0, 1, 3, 0, waits, got);
        idle(2);
        send_word(8'h00, 1'b1, 0, 0, 0, waits, got);
        check("t5_after_flush", got, 0);

        // flush in IDLE blocks a same-cycle word
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_word  = 8'h6D;
        #1;
        check("idle_flush_in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        m_force      = 1'b1;
        idle(2);

        // async reset mid-word, next keep=1 word clears
        send_word(8'h6D, 1'b0, 2, 4, 0, waits, got);
        idle(1);
        send_word(8'h6D, 1'b1, 0, 0, 0, waits, got);
        check("t6_after_reset", got, 2);
        idle(1);

        // random words
        for (int n = 0; n < 60; n++) begin
            int r;
            int kind;
            r    = int'($urandom_range(0, 15));
            kind = (r == 0) ? 2 : ((r < 3) ? 1 : 0);
            send_word(WORD_W'($urandom), 1'($urandom_range(0, 1)), kind,
                      int'($urandom_range(0, WORD_W - 1)), int'($urandom_range(0, 3)) % 3,
                      waits, got);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
